// File: rtl/calc_pkg.sv
// Shared operator codes, FSM state encoding and default operand width
// for the calculator arithmetic stage.
package calc_pkg;

    localparam int DEFAULT_WIDTH = 8;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_MUL  = 3'b010;
    localparam logic [2:0] OP_DIV  = 3'b011;
    localparam logic [2:0] OP_NONE = 3'b100;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDSUB,
        ST_MUL,
        ST_DIV,
        ST_ERR
    } state_t;

endpackage

// File: rtl/calc_engine_seq_muldiv.sv
// Iterative magnitude multiplier (shift-add) and restoring divider sharing
// one 2*WIDTH accumulator; done_o pulses after the last of WIDTH steps.
import calc_pkg::*;

module seq_muldiv #(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 abort_i,
    input  logic                 start_i,
    input  logic                 isDiv_i,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    output logic                 done_o,
    output logic [2*WIDTH-1:0]   acc_o
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] STEPS = CW'(WIDTH);

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   b_q;
    logic               isDiv_q;
    logic [CW-1:0]      cnt_q;
    logic               done_q;

    logic [WIDTH:0] mulSum;
    logic [WIDTH:0] divShift;
    logic [WIDTH:0] divTrial;

    // Multiply: upper half accumulates B, whole register shifts right.
    // Divide: upper half is the partial remainder, lower half fills with quotient bits.
    assign mulSum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, b_q};
    assign divShift = acc_q[2*WIDTH-1:WIDTH-1];
    assign divTrial = divShift - {1'b0, b_q};

    always_comb begin
        acc_d = acc_q;
        if (isDiv_q) begin
            if (divTrial[WIDTH]) begin
                acc_d = {divShift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
            end else begin
                acc_d = {divTrial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            end
        end else if (acc_q[0]) begin
            acc_d = {mulSum, acc_q[WIDTH-1:1]};
        end else begin
            acc_d = {1'b0, acc_q[2*WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q   <= '0;
            b_q     <= '0;
            isDiv_q <= 1'b0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else if (abort_i) begin
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start_i) begin
                acc_q   <= {{WIDTH{1'b0}}, a_i};
                b_q     <= b_i;
                isDiv_q <= isDiv_i;
                cnt_q   <= STEPS;
            end else if (cnt_q != '0) begin
                acc_q <= acc_d;
                cnt_q <= cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign done_o = done_q;
    assign acc_o  = acc_q;

endmodule

// File: rtl/calc_engine.sv
// Sign-magnitude calculator stage: operator latch, execute edge detect,
// one-cycle add/sub and iterative multiply/divide with divide-by-zero flag.
import calc_pkg::*;

module calc_engine #(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     value_a,
    input  logic [WIDTH-1:0]     value_b,
    input  logic                 sign_a,
    input  logic                 sign_b,
    input  logic [2:0]           op,
    input  logic                 execute,
    input  logic                 clear,
    output logic [2*WIDTH-1:0]   result,
    output logic                 result_neg,
    output logic [WIDTH-1:0]     remainder,
    output logic [2:0]           op_latched,
    output logic                 busy,
    output logic                 done,
    output logic                 err_div0
);

    state_t             state_q;
    logic               exec_q;
    logic [2:0]         opLatched_q, opWork_q;
    logic [WIDTH-1:0]   aMag_q, bMag_q;
    logic               signA_q, signB_q;
    logic [2*WIDTH-1:0] result_q;
    logic               resultNeg_q;
    logic [WIDTH-1:0]   remainder_q;
    logic               busy_q, done_q, errDiv0_q;

    logic               startReq, startMd, mdDone;
    logic [2*WIDTH-1:0] mdAcc;
    logic               effSignB, addNeg, prodNeg, quotNeg;
    logic [WIDTH:0]     addMag;

    // Only codes 000..011 are real operators, so bit 2 set means nothing is armed.
    assign startReq = execute && !exec_q && (state_q == ST_IDLE) && !clear && !opLatched_q[2];
    assign startMd  = startReq && ((opLatched_q == OP_MUL) ||
                                   ((opLatched_q == OP_DIV) && (value_b != '0)));

    assign effSignB = signB_q ^ (opWork_q == OP_SUB);

    always_comb begin
        addMag = {1'b0, aMag_q} + {1'b0, bMag_q};
        addNeg = signA_q;
        if (signA_q != effSignB) begin
            if (aMag_q >= bMag_q) begin
                addMag = {1'b0, aMag_q - bMag_q};
                addNeg = signA_q;
            end else begin
                addMag = {1'b0, bMag_q - aMag_q};
                addNeg = effSignB;
            end
        end
        if (addMag == '0) begin
            addNeg = 1'b0;
        end
    end

    assign prodNeg = (signA_q ^ signB_q) && (mdAcc != '0);
    assign quotNeg = (signA_q ^ signB_q) && (mdAcc[WIDTH-1:0] != '0);

    seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk     (clk),
        .rst_n   (rst_n),
        .abort_i (clear),
        .start_i (startMd),
        .isDiv_i (opLatched_q == OP_DIV),
        .a_i     (value_a),
        .b_i     (value_b),
        .done_o  (mdDone),
        .acc_o   (mdAcc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            exec_q      <= 1'b0;
            opLatched_q <= OP_NONE;
            opWork_q    <= OP_NONE;
            aMag_q      <= '0;
            bMag_q      <= '0;
            signA_q     <= 1'b0;
            signB_q     <= 1'b0;
            result_q    <= '0;
            resultNeg_q <= 1'b0;
            remainder_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            errDiv0_q   <= 1'b0;
        end else begin
            exec_q <= execute;
            done_q <= 1'b0;
            if (clear) begin
                state_q     <= ST_IDLE;
                opLatched_q <= OP_NONE;
                result_q    <= '0;
                resultNeg_q <= 1'b0;
                remainder_q <= '0;
                busy_q      <= 1'b0;
                errDiv0_q   <= 1'b0;
            end else begin
                if (op != OP_NONE) begin
                    opLatched_q <= op;
                end
                case (state_q)
                    ST_IDLE: begin
                        if (startReq) begin
                            aMag_q    <= value_a;
                            bMag_q    <= value_b;
                            signA_q   <= sign_a;
                            signB_q   <= sign_b;
                            opWork_q  <= opLatched_q;
                            busy_q    <= 1'b1;
                            errDiv0_q <= 1'b0;
                            if (opLatched_q == OP_MUL) begin
                                state_q <= ST_MUL;
                            end else if (opLatched_q == OP_DIV) begin
                                state_q <= (value_b == '0) ? ST_ERR : ST_DIV;
                            end else begin
                                state_q <= ST_ADDSUB;
                            end
                        end
                    end
                    ST_ADDSUB: begin
                        result_q    <= {{(WIDTH-1){1'b0}}, addMag};
                        resultNeg_q <= addNeg;
                        remainder_q <= '0;
                        done_q      <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                    ST_MUL: begin
                        if (mdDone) begin
                            result_q    <= mdAcc;
                            resultNeg_q <= prodNeg;
                            remainder_q <= '0;
                            done_q      <= 1'b1;
                            busy_q      <= 1'b0;
                            state_q     <= ST_IDLE;
                        end
                    end
                    ST_DIV: begin
                        if (mdDone) begin
                            result_q    <= {{WIDTH{1'b0}}, mdAcc[WIDTH-1:0]};
                            resultNeg_q <= quotNeg;
                            remainder_q <= mdAcc[2*WIDTH-1:WIDTH];
                            done_q      <= 1'b1;
                            busy_q      <= 1'b0;
                            state_q     <= ST_IDLE;
                        end
                    end
                    ST_ERR: begin
                        errDiv0_q   <= 1'b1;
                        result_q    <= '0;
                        resultNeg_q <= 1'b0;
                        remainder_q <= '0;
                        done_q      <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                    default: begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign result     = result_q;
    assign result_neg = resultNeg_q;
    assign remainder  = remainder_q;
    assign op_latched = opLatched_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err_div0   = errDiv0_q;

endmodule

// File: tb/tb_calc_engine.sv
// Scoreboard bench for calc_engine: expected results are computed from signed
// integer arithmetic when an operation is launched and checked on each done pulse.
module tb_calc_engine;
    import calc_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  value_a = '0, value_b = '0;
    logic        sign_a = 1'b0, sign_b = 1'b0;
    logic [2:0]  op = OP_NONE;
    logic        execute = 1'b0, clear = 1'b0;
    logic [15:0] result;
    logic        result_neg;
    logic [7:0]  remainder;
    logic [2:0]  op_latched;
    logic        busy, done, err_div0;

    typedef struct {
        logic [15:0] result;
        logic        neg;
        logic [7:0]  rem;
        logic        err;
    } expect_t;

    expect_t expQ[$];
    int checkCount = 0;
    int failCount = 0;
    int doneCount = 0;

    calc_engine #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .value_a    (value_a),
        .value_b    (value_b),
        .sign_a     (sign_a),
        .sign_b     (sign_b),
        .op         (op),
        .execute    (execute),
        .clear      (clear),
        .result     (result),
        .result_neg (result_neg),
        .remainder  (remainder),
        .op_latched (op_latched),
        .busy       (busy),
        .done       (done),
        .err_div0   (err_div0)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic expect_t model(input logic [2:0] opv, input logic [7:0] a, input logic sa,
                                      input logic [7:0] b, input logic sb);
        expect_t e;
        int va, vb, r;
        va = sa ? -int'(a) : int'(a);
        vb = sb ? -int'(b) : int'(b);
        e.rem = '0;
        e.err = 1'b0;
        r = 0;
        case (opv)
            OP_ADD: r = va + vb;
            OP_SUB: r = va - vb;
            OP_MUL: r = va * vb;
            default: begin
                if (b == 8'd0) begin
                    e.err = 1'b1;
                end else begin
                    r = va / vb;
                    e.rem = 8'(int'(a) % int'(b));
                end
            end
        endcase
        e.result = 16'((r < 0) ? -r : r);
        e.neg = (r < 0);
        return e;
    endfunction

    // Every done pulse must be matched by a queued expectation
    always @(negedge clk) begin
        expect_t e;
        if (rst_n && done === 1'b1) begin
            doneCount++;
            checkOutput("busyLowWithDone", 32'(busy), 32'd0);
            if (expQ.size() == 0) begin
                checkOutput("unexpectedDone", 32'd1, 32'd0);
            end else begin
                e = expQ.pop_front();
                checkOutput("result", 32'(result), 32'(e.result));
                checkOutput("resultNeg", 32'(result_neg), 32'(e.neg));
                checkOutput("remainder", 32'(remainder), 32'(e.rem));
                checkOutput("errDiv0", 32'(err_div0), 32'(e.err));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic startOp(input logic [2:0] opv, input logic [7:0] a, input logic sa,
                           input logic [7:0] b, input logic sb);
        op = opv;
        value_a = a;
        sign_a = sa;
        value_b = b;
        sign_b = sb;
        tick();
        execute = 1'b1;
        tick();
    endtask

    task automatic applyStimulus(input string tag, input logic [2:0] opv, input logic [7:0] a,
                                 input logic sa, input logic [7:0] b, input logic sb,
                                 input int expBusy, input int hold);
        int busyCycles;
        int doneBefore;
        bit got;
        busyCycles = 0;
        got = 1'b0;
        expQ.push_back(model(opv, a, sa, b, sb));
        startOp(opv, a, sa, b, sb);
        for (int i = 0; i < 30 && !got; i++) begin
            if (done === 1'b1) begin
                got = 1'b1;
            end else begin
                if (busy === 1'b1) busyCycles++;
                tick();
            end
        end
        checkOutput({tag, ".doneSeen"}, 32'(got), 32'd1);
        if (!got && expQ.size() > 0) void'(expQ.pop_back());
        checkOutput({tag, ".busyCycles"}, 32'(busyCycles), 32'(expBusy));
        tick();
        checkOutput({tag, ".donePulseWidth"}, 32'(done), 32'd0);
        doneBefore = doneCount;
        repeat (hold) tick();
        checkOutput({tag, ".singleDonePerPress"}, 32'(doneCount - doneBefore), 32'd0);
        execute = 1'b0;
        tick();
    endtask

    initial begin
        int doneBefore;

        repeat (2) tick();
        checkOutput("reset.result", 32'(result), 32'd0);
        checkOutput("reset.resultNeg", 32'(result_neg), 32'd0);
        checkOutput("reset.remainder", 32'(remainder), 32'd0);
        checkOutput("reset.opLatched", 32'(op_latched), 32'(OP_NONE));
        checkOutput("reset.busy", 32'(busy), 32'd0);
        checkOutput("reset.done", 32'(done), 32'd0);
        checkOutput("reset.errDiv0", 32'(err_div0), 32'd0);
        rst_n = 1'b1;
        tick();

        applyStimulus("add", OP_ADD, 8'h12, 1'b0, 8'h34, 1'b0, 1, 2);
        applyStimulus("subNeg", OP_SUB, 8'h05, 1'b0, 8'h09, 1'b0, 1, 2);
        applyStimulus("subZero", OP_SUB, 8'h09, 1'b1, 8'h09, 1'b1, 1, 2);
        applyStimulus("addMax", OP_ADD, 8'hFF, 1'b0, 8'hFF, 1'b0, 1, 2);
        applyStimulus("addBLarger", OP_ADD, 8'h10, 1'b0, 8'h30, 1'b1, 1, 2);
        applyStimulus("mulMax", OP_MUL, 8'hFF, 1'b1, 8'hFF, 1'b0, 9, 20);
        applyStimulus("mulZero", OP_MUL, 8'h00, 1'b1, 8'h05, 1'b1, 9, 2);
        applyStimulus("div", OP_DIV, 8'h64, 1'b1, 8'h07, 1'b0, 9, 2);
        applyStimulus("divZero", OP_DIV, 8'h2A, 1'b0, 8'h00, 1'b0, 1, 2);
        checkOutput("divZero.errHeld", 32'(err_div0), 32'd1);
        applyStimulus("divAfterErr", OP_DIV, 8'hC8, 1'b0, 8'h03, 1'b1, 9, 2);
        applyStimulus("divSmall", OP_DIV, 8'h03, 1'b1, 8'h07, 1'b0, 9, 2);

        // Clear in the middle of a multiply aborts it silently
        startOp(OP_MUL, 8'h0B, 1'b0, 8'h0D, 1'b0);
        repeat (3) tick();
        clear = 1'b1;
        op = OP_NONE;
        tick();
        checkOutput("clearMul.busy", 32'(busy), 32'd0);
        checkOutput("clearMul.result", 32'(result), 32'd0);
        checkOutput("clearMul.remainder", 32'(remainder), 32'd0);
        checkOutput("clearMul.opLatched", 32'(op_latched), 32'(OP_NONE));
        clear = 1'b0;
        execute = 1'b0;
        doneBefore = doneCount;
        repeat (12) tick();
        checkOutput("clearMul.noDone", 32'(doneCount - doneBefore), 32'd0);

        execute = 1'b1;
        tick();
        checkOutput("noneArmed.busy", 32'(busy), 32'd0);
        repeat (3) tick();
        checkOutput("noneArmed.noDone", 32'(doneCount - doneBefore), 32'd0);
        execute = 1'b0;
        tick();

        op = OP_ADD;
        value_a = 8'h01;
        value_b = 8'h02;
        tick();
        clear = 1'b1;
        execute = 1'b1;
        tick();
        checkOutput("clearWithExec.busy", 32'(busy), 32'd0);
        checkOutput("clearWithExec.opLatched", 32'(op_latched), 32'(OP_NONE));
        clear = 1'b0;
        tick();
        checkOutput("heldExecAfterClear.busy", 32'(busy), 32'd0);
        execute = 1'b0;
        repeat (2) tick();
        checkOutput("clearWithExec.noDone", 32'(doneCount - doneBefore), 32'd0);

        applyStimulus("addMixed", OP_ADD, 8'h10, 1'b0, 8'h30, 1'b1, 1, 2);

        // Asynchronous reset between edges in the middle of a divide
        startOp(OP_DIV, 8'hC8, 1'b0, 8'h05, 1'b0);
        repeat (2) tick();
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("asyncReset.result", 32'(result), 32'd0);
        checkOutput("asyncReset.resultNeg", 32'(result_neg), 32'd0);
        checkOutput("asyncReset.remainder", 32'(remainder), 32'd0);
        checkOutput("asyncReset.opLatched", 32'(op_latched), 32'(OP_NONE));
        checkOutput("asyncReset.busy", 32'(busy), 32'd0);
        checkOutput("asyncReset.done", 32'(done), 32'd0);
        execute = 1'b0;
        op = OP_NONE;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        applyStimulus("addAfterReset", OP_ADD, 8'h21, 1'b0, 8'h0F, 1'b1, 1, 2);

        repeat (3) tick();
        checkOutput("scoreboardDrained", 32'(expQ.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
